// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial-pattern detector.
// State encodings are fixed so the debug state port decodes the same in every build.
package seq_detect_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_EMPTY = 2'd0,
      S_FILL  = 2'd1,
      S_FULL  = 2'd2,
      S_MATCH = 2'd3
   } state_t;

   // Width needed to count 0..pat_w valid history bits.
   function automatic int fill_w(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// History shift register with a saturating count of valid bits.
// flush alone empties the history; flush with shift restarts it holding only x.
module seq_hist_shreg #(
   parameter int PAT_W  = 4,
   parameter int FILL_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              shift,
   input  logic              flush,
   input  logic              x,
   output logic [PAT_W-1:0]  hist,
   output logic [FILL_W-1:0] fill
);

   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist <= '0;
         fill <= '0;
      end else if (flush && shift) begin
         hist <= {{(PAT_W-1){1'b0}}, x};
         fill <= FILL_W'(1);
      end else if (flush) begin
         hist <= '0;
         fill <= '0;
      end else if (shift) begin
         hist <= {hist[PAT_W-2:0], x};
         if (fill != FILL_MAX)
            fill <= fill + FILL_W'(1);
      end
   end

endmodule

// File: rtl/seq_detect_param.sv
// Moore detector for a run-time-loadable PAT_W-bit pattern with a saturating match count.
// Define SEQ_DETECT_PARITY_EN to add the ones_odd parity output.
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      x,
   input  logic                      x_valid,
   input  logic [PAT_W-1:0]          pattern,
   input  logic                      pattern_ld,
   input  logic                      overlap,
   input  logic                      clear,
   output logic                      y,
   output logic [CNT_W-1:0]          match_count,
   output logic [fill_w(PAT_W)-1:0]  fill,
`ifdef SEQ_DETECT_PARITY_EN
   output logic                      ones_odd,
`endif
   output logic [STATE_W-1:0]        state_dbg
);

   localparam int FILL_W = fill_w(PAT_W);

   // Input handshake: x is consumed on a rising edge only when x_valid is high and
   // neither clear nor pattern_ld is asserted; there is no back-pressure.

   state_t            state;
   state_t            state_nx;
   logic [PAT_W-1:0]  pat_reg;
   logic [PAT_W-1:0]  hist;
   logic [PAT_W-1:0]  hist_nx;
   logic              restart;
   logic              full_nx;
   logic              match;
   logic              shift;
   logic              flush;
   logic              restart_req;

   seq_hist_shreg #(
      .PAT_W  (PAT_W),
      .FILL_W (FILL_W)
   ) u_hist (
      .clk     (clk),
      .reset_n (reset_n),
      .shift   (shift),
      .flush   (flush),
      .x       (x),
      .hist    (hist),
      .fill    (fill)
   );

   assign restart_req = clear || pattern_ld;

   always_comb begin
      // Non-overlap mode leaving S_MATCH treats the history as empty first.
      restart  = (state == S_MATCH) && !overlap;
      hist_nx  = restart ? {{(PAT_W-1){1'b0}}, x} : {hist[PAT_W-2:0], x};
      full_nx  = !restart && (fill >= FILL_W'(PAT_W-1));
      match    = !restart_req && x_valid && full_nx && (hist_nx == pat_reg);
      shift    = 1'b0;
      flush    = 1'b0;
      state_nx = state;
      if (restart_req) begin
         flush    = 1'b1;
         state_nx = S_EMPTY;
      end else if (x_valid) begin
         shift = 1'b1;
         flush = restart;
         if (match)
            state_nx = S_MATCH;
         else if (full_nx)
            state_nx = S_FULL;
         else
            state_nx = S_FILL;
      end else begin
         case (state)
            S_MATCH: begin
               if (overlap) begin
                  state_nx = S_FULL;
               end else begin
                  state_nx = S_EMPTY;
                  flush    = 1'b1;
               end
            end
            S_EMPTY, S_FILL, S_FULL: state_nx = state;
            default: state_nx = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_EMPTY;
         y           <= 1'b0;
         pat_reg     <= '0;
         match_count <= '0;
      end else begin
         state <= state_nx;
         y     <= (state_nx == S_MATCH);
         if (pattern_ld)
            pat_reg <= pattern;
         if (clear)
            match_count <= '0;
         else if (match && (match_count != {CNT_W{1'b1}}))
            match_count <= match_count + CNT_W'(1);
      end
   end

`ifdef SEQ_DETECT_PARITY_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ones_odd <= 1'b0;
      else if (restart_req)
         ones_odd <= 1'b0;
      else if (x_valid && x)
         ones_odd <= ~ones_odd;
   end
`endif

   assign state_dbg = state;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus random traffic against a queue-based model.
// Two instances share inputs: CNT_W=8 and CNT_W=2 (counter saturation).
module tb_seq_detect_param;

   localparam int PAT_W = 4;

   logic             clk;
   logic             reset_n;
   logic             x;
   logic             x_valid;
   logic [PAT_W-1:0] pattern;
   logic             pattern_ld;
   logic             overlap;
   logic             clear;
   logic             y,  y2;
   logic [7:0]       cnt8;
   logic [1:0]       cnt2;
   logic [2:0]       fill, fill2;
   logic [1:0]       st, st2;
`ifdef SEQ_DETECT_PARITY_EN
   logic             odd, odd2;
`endif

   seq_detect_param #(.PAT_W(PAT_W), .CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .pattern(pattern),
      .pattern_ld(pattern_ld), .overlap(overlap), .clear(clear), .y(y),
      .match_count(cnt8), .fill(fill),
`ifdef SEQ_DETECT_PARITY_EN
      .ones_odd(odd),
`endif
      .state_dbg(st)
   );

   seq_detect_param #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .pattern(pattern),
      .pattern_ld(pattern_ld), .overlap(overlap), .clear(clear), .y(y2),
      .match_count(cnt2), .fill(fill2),
`ifdef SEQ_DETECT_PARITY_EN
      .ones_odd(odd2),
`endif
      .state_dbg(st2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: accepted bits since the last restart point, newest at the back
   bit               m_q[$];
   logic [PAT_W-1:0] m_pat;
   bit               m_match;
   int               m_cnt8, m_cnt2, m_ones;

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_pat   = '0;
      m_match = 1'b0;
      m_cnt8  = 0;
      m_cnt2  = 0;
      m_ones  = 0;
   endtask

   task automatic model_step(input bit xv, input bit xb, input bit ov, input bit cl,
                             input bit ld, input logic [PAT_W-1:0] pat);
      logic [PAT_W-1:0] w;
      if (cl) begin
         m_q.delete();
         m_match = 1'b0;
         m_cnt8  = 0;
         m_cnt2  = 0;
         m_ones  = 0;
         if (ld) m_pat = pat;
      end else if (ld) begin
         m_pat = pat;
         m_q.delete();
         m_match = 1'b0;
         m_ones  = 0;
      end else if (xv) begin
         if (m_match && !ov) m_q.delete();
         m_q.push_back(xb);
         if (m_q.size() > PAT_W) void'(m_q.pop_front());
         m_ones += int'(xb);
         w = '0;
         foreach (m_q[i]) w = {w[PAT_W-2:0], m_q[i]};
         m_match = (m_q.size() == PAT_W) && (w == m_pat);
         if (m_match) begin
            m_cnt8 = min_i(m_cnt8 + 1, 255);
            m_cnt2 = min_i(m_cnt2 + 1, 3);
         end
      end else begin
         if (m_match && !ov) m_q.delete();
         m_match = 1'b0;
      end
   endtask

   function automatic int exp_state();
      int f;
      f = min_i(m_q.size(), PAT_W);
      if (m_match) return 3;
      if (f == 0) return 0;
      if (f < PAT_W) return 1;
      return 2;
   endfunction

   task automatic check_all();
      int f;
      f = min_i(m_q.size(), PAT_W);
      check("y", int'(y), int'(m_match));
      check("y2", int'(y2), int'(m_match));
      check("fill", int'(fill), f);
      check("fill2", int'(fill2), f);
      check("state", int'(st), exp_state());
      check("cnt8", int'(cnt8), m_cnt8);
      check("cnt2", int'(cnt2), m_cnt2);
`ifdef SEQ_DETECT_PARITY_EN
      check("ones_odd", int'(odd), m_ones % 2);
      check("ones_odd2", int'(odd2), m_ones % 2);
`endif
   endtask

   // driver: apply one cycle of inputs, advance model at the edge, check 1 time unit later
   task automatic step(input bit xv, input bit xb, input bit ov, input bit cl,
                       input bit ld, input logic [PAT_W-1:0] pat);
      x_valid    = xv;
      x          = xb;
      overlap    = ov;
      clear      = cl;
      pattern_ld = ld;
      pattern    = pat;
      @(posedge clk);
      model_step(xv, xb, ov, cl, ld, pat);
      #1;
      check_all();
   endtask

   task automatic feed(input bit xb, input bit ov);
      step(1'b1, xb, ov, 1'b0, 1'b0, '0);
   endtask

   task automatic idle(input bit ov);
      step(1'b0, 1'b0, ov, 1'b0, 1'b0, '0);
   endtask

   task automatic restart_with(input logic [PAT_W-1:0] pat, input bit ov);
      step(1'b0, 1'b0, ov, 1'b1, 1'b1, pat);
   endtask

   initial begin
      bit stream [7];
      stream = '{1, 0, 1, 1, 0, 1, 1};
      reset_n = 1'b0;
      x = 0; x_valid = 0; pattern = '0; pattern_ld = 0; overlap = 0; clear = 0;
      model_reset();

      // reset held with x_valid toggling
      for (int i = 0; i < 4; i++) begin
         x_valid = ~x_valid;
         x       = 1'b1;
         @(posedge clk);
         #1;
         check_all();
      end
      @(negedge clk);
      reset_n = 1'b1;
      feed(1'b1, 1'b1);
      check("rst_first_fill", int'(fill), 1);

      // overlapping detection
      restart_with(4'b1011, 1'b1);
      for (int i = 0; i < 7; i++) begin
         feed(stream[i], 1'b1);
         if (i == 3 || i == 6) check("ovl_pulse", int'(y), 1);
      end
      idle(1'b1);
      check("ovl_cnt", int'(cnt8), 2);

      // non-overlapping detection
      restart_with(4'b1011, 1'b0);
      for (int i = 0; i < 7; i++) begin
         feed(stream[i], 1'b0);
         if (i == 6) check("novl_no_pulse", int'(y), 0);
      end
      check("novl_fill", int'(fill), 3);
      check("novl_cnt", int'(cnt8), 1);

      // valid gaps
      restart_with(4'b1011, 1'b1);
      for (int i = 0; i < 4; i++) begin
         feed(stream[i], 1'b1);
         if (i < 3) begin
            idle(1'b1);
            idle(1'b1);
            check("gap_fill_hold", int'(fill), i + 1);
         end
      end
      check("gap_pulse", int'(y), 1);
      idle(1'b1);
      check("gap_pulse_end", int'(y), 0);

      // saturation on the narrow counter
      restart_with(4'b1111, 1'b1);
      for (int i = 0; i < 8; i++) feed(1'b1, 1'b1);
      check("sat_cnt2", int'(cnt2), 3);
      check("sat_cnt8", int'(cnt8), 5);

      // clear and load together with a valid bit: bit is dropped
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
      check("prio_cnt", int'(cnt8), 0);
      check("prio_fill", int'(fill), 0);
      feed(1'b0, 1'b1); feed(1'b1, 1'b1); feed(1'b1, 1'b1); feed(1'b0, 1'b1);
      check("prio_newpat", int'(y), 1);

      // load alone keeps the counter
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1001);
      check("ld_keeps_cnt", int'(cnt8), 1);

      // asynchronous reset mid-pattern
      feed(1'b1, 1'b1); feed(1'b0, 1'b1); feed(1'b0, 1'b1);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      reset_n = 1'b1;
      restart_with(4'b1001, 1'b1);
      for (int i = 0; i < 3; i++) feed((i == 0) ? 1'b1 : 1'b0, 1'b1);
      check("rst_no_early", int'(y), 0);
      feed(1'b1, 1'b1);
      check("rst_full4", int'(y), 1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bit              xv, xb, ov, cl, ld;
         logic [PAT_W-1:0] p;
         xv = ($urandom_range(0, 9) < 7);
         xb = $urandom_range(0, 1);
         ov = ($urandom_range(0, 15) != 0) ? overlap : ~overlap;
         cl = ($urandom_range(0, 199) == 0);
         ld = ($urandom_range(0, 79) == 0);
         p  = PAT_W'($urandom_range(0, 15));
         step(xv, xb, ov, cl, ld, p);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised Moore serial-pattern detector; next generation of the lab's fixed-pattern detector FSMs.
- Detects a run-time-loadable PAT_W-bit pattern on a 1-bit serial stream with a valid qualifier.
- Mode input selects overlapping or non-overlapping detection; saturating match counter.
- Sits between the debounced switch/serial input logic and the LED/seven-segment display logic.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, match counter width; legal range 1..16.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is accepted on a rising edge only when this is high.
- pattern  in  PAT_W  pattern to load; bit PAT_W-1 is the oldest bit.
- pattern_ld  in  1  synchronous load of pattern into the internal pattern register; also restarts detection.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- clear  in  1  synchronous restart; also zeroes match_count.
- y  out  1  Moore match output; high exactly when state == S_MATCH.
- match_count  out  CNT_W  number of matches since reset/clear; saturating.
- fill  out  clog2(PAT_W+1)  number of valid bits currently held in history; saturates at PAT_W.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=S_EMPTY, hist=0, fill=0, pat_reg=0, y=0, match_count=0.
- On an accepted bit: hist_next = {hist[PAT_W-2:0], x}; fill_next = min(fill+1, PAT_W).
- Match event: accepted bit with fill_next==PAT_W and hist_next==pat_reg.
  - Next state is S_MATCH; y is high for the cycle after the sampling edge (latency 1).
- States:
  - S_EMPTY: fill==0.
  - S_FILL: 0<fill<PAT_W.
  - S_FULL: fill==PAT_W, no match this cycle.
  - S_MATCH: Moore accept state.
- Transitions on an accepted bit, without a match event:
  - From S_EMPTY, S_FILL, S_FULL: go to S_FILL or S_FULL according to fill_next.
  - From S_MATCH, overlap=1: go to S_FULL.
  - From S_MATCH, overlap=0: history treated as empty first; this bit becomes fill=1, hist=x; state S_FILL.
- Any match event: go to S_MATCH, including back-to-back matches (y stays high).
- No accepted bit (x_valid=0):
  - hist and fill hold.
  - S_MATCH exits after one cycle: overlap=1 -> S_FULL; overlap=0 -> S_EMPTY with fill=0 and hist=0.
  - All other states hold.
- Non-overlap mode: PAT_W new bits are required after every match before the next match.
- match_count increments by 1 on each match event and saturates at 2^CNT_W-1 (no wrap).
- Priority: clear > pattern_ld > x_valid.
  - clear: state=S_EMPTY, fill=0, hist=0, match_count=0. If pattern_ld is also high, pat_reg still loads.
  - pattern_ld: pat_reg=pattern, state=S_EMPTY, fill=0, hist=0; match_count is kept; x that cycle is discarded.
- Reset mid-operation: all registers return to reset values immediately; no pulse on y.
- Unreachable state encodings: go to S_EMPTY.

Optional Feature:
- Macro: SEQ_DETECT_PARITY_EN.
- Defined: adds output port ones_odd (1 bit).
  - Toggles on every accepted x=1.
  - Cleared by reset, clear and pattern_ld.
  - Reports odd (1) or even (0) count of ones since restart.
- Undefined: ones_odd port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package seq_detect_pkg holds:
  - State localparams S_EMPTY=0, S_FILL=1, S_FULL=2, S_MATCH=3, with a 2-bit state width constant.
  - A function computing the fill width from PAT_W.
- One sub-module, seq_hist_shreg, holds the PAT_W-bit history shift register with fill counter.
  - Inputs: shift, flush, x.
  - Outputs: hist, fill.
- The FSM and counter live in the top module.

Test Plan (PAT_W=4, CNT_W=8 unless stated):
- Reset: hold reset_n=0 with x_valid=1 toggling -> y=0, match_count=0, fill=0. Release reset_n -> first accepted bit gives fill=1.
- Overlap: load 4'b1011, overlap=1, feed 1,0,1,1,0,1,1 -> y pulses after bit 4 and after bit 7; match_count=2.
- Non-overlap: same load and stream with overlap=0 -> y pulses after bit 4 only; fill=3 at the end; match_count=1.
- Valid gaps: feed 1,0,1,1 with 2 idle cycles between each bit -> one y pulse, one cycle after bit 4; fill holds through the gaps.
- Saturation: CNT_W=2, 4'b1111, overlap=1, feed 8 ones -> matches on bits 4..8; y high for 5 consecutive cycles; match_count stops at 3.
- Priority and restart:
  - clear and pattern_ld asserted together with x_valid=1 -> match_count=0, fill=0, new pattern loaded, x ignored.
  - reset_n pulsed low mid-pattern -> next match needs a full 4 new bits.
